ex_alu_unit: RTL and testbench
==============================

EX_ALU_UNIT -- requirements
Module: ex_alu_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation offered.
REQ-005 SHALL have port in_ready  output  1  unit can accept an operation.
REQ-006 SHALL have port alu_ctrl  input  4  operation code from alu_control, encodings per define.v; 4'b1111 = illegal.
REQ-007 SHALL have port op_a  input  XLEN  first operand (rs1).
REQ-008 SHALL have port op_b  input  XLEN  second operand (rs2 or immediate).
REQ-009 SHALL have port pc_in  input  XLEN  instruction PC (JUMP only).
REQ-010 SHALL have port flush  input  1  synchronous kill of any in-flight operation.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  XLEN  registered result.
REQ-014 SHALL have port zero  output  1  result == 0 (branch decision for `SUB).
REQ-015 SHALL have port illegal  output  1  accepted code was not a defined operation.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-017 SHALL accept an operation on a clk edge where in_valid && in_ready && !flush, capturing alu_ctrl, op_a, op_b, pc_in.
REQ-018 SHALL compute `ADD a+b, `SUB a-b, `XOR, `OR, `AND bitwise, all modulo 2^XLEN, carry discarded.
REQ-019 SHALL return 1/0 in bit 0, upper bits 0: `SLT signed a<b, `SLTU unsigned a<b, `SGE signed a>=b, `SGEU unsigned a>=b, `NOTEQ a!=b.
REQ-020 SHALL compute `JUMP as pc_in+4.
REQ-021 Non-shift ops SHALL go IDLE->DONE on the accept edge: out_valid high the following cycle (latency 1).
REQ-022 `SLL/`SRL/`SRA SHALL use shift amount op_b[4:0] (op_b[5:0] when XLEN=64), shifting by one bit per cycle in SHIFT; `SRA replicates sign bit.
REQ-023 Shift with amount 0 SHALL go IDLE->DONE directly (latency 1); amount N>0 SHALL take IDLE->SHIFT, N cycles in SHIFT, then DONE (out_valid N+1 cycles after accept).
REQ-024 Undefined alu_ctrl (incl. 4'b1111) SHALL complete with latency 1, result 0, illegal 1; illegal 0 for all defined codes.
REQ-025 In DONE, result/zero/illegal SHALL hold stable while out_valid && !out_ready.
REQ-026 DONE SHALL return to IDLE on out_ready; no back-to-back accept in the same cycle (one op in flight max).
REQ-027 flush SHALL force IDLE next edge from any state, clear out_valid, and block any accept that cycle; flush has priority over in_valid and out_ready.
REQ-028 zero SHALL be combinationally derived from the registered result.

Reset
REQ-029 On rst assertion, SHALL immediately enter IDLE with out_valid 0, result 0, zero 1, illegal 0, shift counter 0, in_ready 1 while rst deasserted.
REQ-030 rst asserted mid-shift SHALL discard the operation; no out_valid after deassertion until a new accept.

Verification
REQ-031 `ADD a=0xFFFFFFFF b=1, out_ready=1 -> out_valid one cycle later, result 0x00000000, zero 1.
REQ-032 `SLT a=0xFFFFFFFF b=1 -> result 1; `SLTU same operands -> result 0; `SGEU -> 1.
REQ-033 `SRA a=0x80000000 b=4 -> in_ready low 5 cycles, out_valid 5 cycles after accept, result 0xF8000000; `SLL b=0 -> latency 1, result=a.
REQ-034 `XOR result with out_ready=0 for 3 cycles -> result/out_valid stable, in_ready 0 until out_ready pulse, then IDLE.
REQ-035 `SRL b=31 started, flush asserted at cycle 10 -> out_valid never rises, in_ready 1 next cycle; rst pulse mid-shift -> same.
REQ-036 alu_ctrl=4'b1111 -> out_valid after 1 cycle, result 0, illegal 1; `JUMP pc_in=0x100 -> result 0x104.

Source files
------------

// File: rtl/ex_alu_if.sv
// Handshake and data bundle between the issue stage and the EX ALU unit.
// No logic; pure wiring, zero latency.
// in_valid/in_ready on the request side; out_valid/out_ready on the result side.
interface ex_alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] pc_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  // Issue side: offers operations and consumes results.
  modport master (
    output in_valid, alu_ctrl, op_a, op_b, pc_in, flush, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  // ALU side.
  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, pc_in, flush, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/ex_alu_unit.sv
// Single-issue ALU with an iterative one-bit-per-cycle shifter.
// Latency 1 for non-shift ops and zero shifts; N+1 cycles for a shift by N.
// One op in flight; result held in DONE until out_ready; flush beats everything.
module ex_alu_unit #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_alu_if.slave  bus
);

  // Operation encodings shared with alu_control.
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_SGE   = 4'd10;
  localparam logic [3:0] OP_SGEU  = 4'd11;
  localparam logic [3:0] OP_NOTEQ = 4'd12;
  localparam logic [3:0] OP_JUMP  = 4'd13;

  // Shift amount width: 5 bits for RV32, 6 bits for RV64.
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [3:0]      op_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] res_q;
  logic            ill_q;

  logic            accept;
  logic            shift_in;
  logic [SHW-1:0]  amt;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic [XLEN-1:0] shift_nx;

  assign accept   = bus.in_valid && (state == IDLE) && !bus.flush;
  assign amt      = bus.op_b[SHW-1:0];
  assign shift_in = (bus.alu_ctrl == OP_SLL) || (bus.alu_ctrl == OP_SRL) ||
                    (bus.alu_ctrl == OP_SRA);

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.zero      = (res_q == '0);
  assign bus.illegal   = ill_q;

  // Single-cycle result for everything except non-zero shifts.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (bus.alu_ctrl)
      OP_ADD:   alu_res = bus.op_a + bus.op_b;
      OP_SUB:   alu_res = bus.op_a - bus.op_b;
      OP_XOR:   alu_res = bus.op_a ^ bus.op_b;
      OP_OR:    alu_res = bus.op_a | bus.op_b;
      OP_AND:   alu_res = bus.op_a & bus.op_b;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
      OP_SGE:   alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) >= $signed(bus.op_b))};
      OP_SGEU:  alu_res = {{(XLEN-1){1'b0}}, (bus.op_a >= bus.op_b)};
      OP_NOTEQ: alu_res = {{(XLEN-1){1'b0}}, (bus.op_a != bus.op_b)};
      OP_JUMP:  alu_res = bus.pc_in + XLEN'(4);
      OP_SLL, OP_SRL, OP_SRA: alu_res = bus.op_a;   // amount-0 shift passes a through
      default:  alu_ill = 1'b1;
    endcase
  end

  // One-bit shift step applied to the working value each SHIFT cycle.
  always_comb begin
    shift_nx = res_q;
    case (op_q)
      OP_SLL:  shift_nx = {res_q[XLEN-2:0], 1'b0};
      OP_SRL:  shift_nx = {1'b0, res_q[XLEN-1:1]};
      OP_SRA:  shift_nx = {res_q[XLEN-1], res_q[XLEN-1:1]};
      default: shift_nx = res_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:  if (accept) state_nx = (shift_in && (amt != '0)) ? SHIFT : DONE;
        SHIFT: if (cnt_q == SHW'(1)) state_nx = DONE;
        DONE:  if (bus.out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Operand capture and iterative shift; res_q doubles as the shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      cnt_q <= '0;
      res_q <= '0;
      ill_q <= 1'b0;
    end else if (!bus.flush) begin
      if (accept) begin
        op_q  <= bus.alu_ctrl;
        ill_q <= alu_ill;
        res_q <= alu_res;
        cnt_q <= shift_in ? amt : '0;
      end else if (state == SHIFT) begin
        res_q <= shift_nx;
        cnt_q <= cnt_q - SHW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed bench for ex_alu_unit: hand-computed vectors, latency and handshake checks.
// Inputs driven and outputs sampled 1ns after the rising edge.
// Every wait on the DUT is bounded.
module tb_ex_alu_unit;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_SGE   = 4'd10;
  localparam logic [3:0] OP_SGEU  = 4'd11;
  localparam logic [3:0] OP_NOTEQ = 4'd12;
  localparam logic [3:0] OP_JUMP  = 4'd13;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  ex_alu_if #(.XLEN(32)) bus ();

  ex_alu_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for exactly one edge; returns 1ns after the accept edge.
  task automatic offer(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc);
    bus.alu_ctrl = c;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.pc_in    = pc;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Full op with out_ready high: latency, result, zero, illegal, return to idle.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_ill);
    int lat;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    offer(c, a, b, pc);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"}, bus.result, exp_res);
    check({tag, ".zero"}, 32'(bus.zero), 32'(exp_res == 32'd0));
    check({tag, ".illegal"}, 32'(bus.illegal), 32'(exp_ill));
    step();
    check({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = 4'd0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.pc_in     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.result", bus.result, 32'd0);
    check("rst.zero", 32'(bus.zero), 32'd1);
    check("rst.illegal", 32'(bus.illegal), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check("post_rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst.out_valid", 32'(bus.out_valid), 32'd0);

    run_op("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'd1, 32'd0, 1, 32'h0000_0000, 1'b0);
    run_op("sub",      OP_SUB,  32'd5, 32'd7, 32'd0, 1, 32'hFFFF_FFFE, 1'b0);
    run_op("sub_eq",   OP_SUB,  32'h1234, 32'h1234, 32'd0, 1, 32'h0, 1'b0);
    run_op("slt",      OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd0, 1, 32'd1, 1'b0);
    run_op("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 32'd0, 1'b0);
    run_op("sge",      OP_SGE,  32'hFFFF_FFFF, 32'd1, 32'd0, 1, 32'd0, 1'b0);
    run_op("sgeu",     OP_SGEU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 32'd1, 1'b0);
    run_op("noteq_eq", OP_NOTEQ, 32'd3, 32'd3, 32'd0, 1, 32'd0, 1'b0);
    run_op("noteq_ne", OP_NOTEQ, 32'd3, 32'd4, 32'd0, 1, 32'd1, 1'b0);
    run_op("xor",      OP_XOR,  32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0, 1, 32'h5A5A_A5A5, 1'b0);
    run_op("or",       OP_OR,   32'hF000_000F, 32'h0F00_00F0, 32'd0, 1, 32'hFF00_00FF, 1'b0);
    run_op("and",      OP_AND,  32'hF0F0_FFFF, 32'h3C3C_00FF, 32'd0, 1, 32'h3030_00FF, 1'b0);
    run_op("jump",     OP_JUMP, 32'hDEAD_BEEF, 32'd9, 32'h0000_0100, 1, 32'h0000_0104, 1'b0);
    run_op("ill_f",    4'hF,    32'd1, 32'd2, 32'd3, 1, 32'd0, 1'b1);
    run_op("ill_e",    4'hE,    32'd7, 32'd7, 32'd0, 1, 32'd0, 1'b1);
    run_op("sll0",     OP_SLL,  32'h1234_5678, 32'd0, 32'd0, 1, 32'h1234_5678, 1'b0);
    run_op("sll_amt",  OP_SLL,  32'h0000_0001, 32'h0000_0021, 32'd0, 2, 32'h0000_0002, 1'b0);
    run_op("sra_neg",  OP_SRA,  32'h8000_0000, 32'd4, 32'd0, 5, 32'hF800_0000, 1'b0);
    run_op("sra_pos",  OP_SRA,  32'h7000_0000, 32'd3, 32'd0, 4, 32'h0E00_0000, 1'b0);
    run_op("srl31",    OP_SRL,  32'h8000_0000, 32'd31, 32'd0, 32, 32'h0000_0001, 1'b0);

    // in_ready stays low for the whole SRA-by-4 plus its DONE cycle.
    offer(OP_SRA, 32'h8000_0000, 32'd4, 32'd0);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 64) begin
      n++;
      step();
    end
    check("sra.busy_cycles", 32'(n), 32'd5);

    // Backpressure: result held, second offer ignored, released by out_ready.
    bus.out_ready = 1'b0;
    offer(OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'd0);
    bus.alu_ctrl = OP_ADD;
    bus.op_a     = 32'd1;
    bus.op_b     = 32'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("hold.out_valid", 32'(bus.out_valid), 32'd1);
      check("hold.result", bus.result, 32'h5A5A_A5A5);
      check("hold.in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("release.out_valid", 32'(bus.out_valid), 32'd0);
    check("release.in_ready", 32'(bus.in_ready), 32'd1);
    check("release.result", bus.result, 32'h5A5A_A5A5);

    // Flush mid-shift: no result ever appears.
    offer(OP_SRL, 32'hFFFF_FFFF, 32'd31, 32'd0);
    repeat (9) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_shift.in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_shift.out_valid", 32'(bus.out_valid), 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) n++;
      step();
    end
    check("flush_shift.late_valid", 32'(n), 32'd0);

    // Flush while holding a result clears out_valid despite out_ready low.
    bus.out_ready = 1'b0;
    offer(OP_AND, 32'hFF, 32'h0F, 32'd0);
    check("flush_done.pre", 32'(bus.out_valid), 32'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    check("flush_done.out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_done.in_ready", 32'(bus.in_ready), 32'd1);

    // Flush blocks an accept offered in the same cycle.
    bus.alu_ctrl = OP_ADD;
    bus.op_a     = 32'd1;
    bus.op_b     = 32'd1;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_accept.out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_accept.in_ready", 32'(bus.in_ready), 32'd1);

    // Reset mid-shift: immediate clear, then nothing until a new accept.
    offer(OP_SRL, 32'hFFFF_FFFF, 32'd31, 32'd0);
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid.result", bus.result, 32'd0);
    check("rst_mid.zero", 32'(bus.zero), 32'd1);
    step();
    rst = 1'b0;
    step();
    check("rst_mid.in_ready", 32'(bus.in_ready), 32'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) n++;
      step();
    end
    check("rst_mid.late_valid", 32'(n), 32'd0);

    run_op("after_rst", OP_ADD, 32'd40, 32'd2, 32'd0, 1, 32'd42, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
